mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the Addr/Rw/En/Data request interface driven by the
//  iterative search controllers. It holds a 2^A_WIDTH x D_WIDTH array and serves
//  single-beat reads and writes with a programmable read latency. A preload port
//  fills the array from the bench or a host, and two saturating counters report
//  access statistics.
// PARAMETERS
//  D_WIDTH  8   data word width; same value as the shared `D_WIDTH
//  A_WIDTH  8   address width; array depth = 2**A_WIDTH
//  RD_LAT   1   read latency in cycles, legal range 1..4; 1 = Data valid the cycle after En
//  CNT_W    16  width of the Rd_cnt and Wr_cnt statistic counters
// PORTS
//  Clk      in   1        single clock; all state on posedge
//  Rst      in   1        asynchronous, active-low reset (0 = reset)
//  En       in   1        access request from the initiator
//  Rw       in   1        0 = read, 1 = write; qualified by En
//  Addr     in   A_WIDTH  access address
//  Wdata    in   D_WIDTH  write data; used only when Rw=1
//  Data     out  D_WIDTH  read data, registered, held until the next read completes
//  Rdy      out  1        1-cycle pulse: Data carries a new read result
//  Busy     out  1        read in flight; En is ignored while Busy=1
//  Wack     out  1        1-cycle pulse the cycle after an accepted write
//  Ld_en    in   1        preload write strobe
//  Ld_addr  in   A_WIDTH  preload address
//  Ld_data  in   D_WIDTH  preload data
//  Ld_ack   out  1        combinational: the preload write this cycle is taken
//  Cnt_clr  in   1        synchronous clear of both counters
//  Rd_cnt   out  CNT_W    accepted reads, saturating at all-ones
//  Wr_cnt   out  CNT_W    accepted access-port writes, saturating; preloads not counted
// BEHAVIOUR
//  Reset (Rst=0, asynchronous):
//   - Data=0, Rdy=0, Busy=0, Wack=0, Rd_cnt=0, Wr_cnt=0; FSM goes to IDLE.
//   - Array contents are not reset.
//   - A read in flight is aborted: no Rdy is issued after reset releases.
//  Accept condition: En=1 and Busy=0 at a posedge. En is level-sampled, so each
//   cycle with En=1 and Busy=0 is a separate access.
//  Read (Rw=0), accepted at edge k:
//   - The array word is sampled at edge k (read-before-write against any write at edge k).
//   - The word is staged through RD_LAT-1 pipeline registers.
//   - Data is updated at edge k+RD_LAT-1; Rdy=1 for exactly the following cycle.
//   - RD_LAT=1: Data updates at edge k and Busy never asserts, so back-to-back reads
//     are allowed every cycle.
//   - RD_LAT>1: Busy=1 from edge k to edge k+RD_LAT-1, i.e. RD_LAT-1 cycles.
//  Write (Rw=1), accepted at edge k: array[Addr] <= Wdata at edge k; Wack=1 for the next
//   cycle. Writes never raise Busy.
//  FSM: IDLE  -(read accepted, RD_LAT>1)-> WAIT (load lat_cnt = RD_LAT-2)
//       WAIT  -(lat_cnt==0)-> IDLE, and Data is loaded on that edge
//       WAIT  -(otherwise)-> WAIT, lat_cnt decrements
//       En is ignored in WAIT. Busy = (state==WAIT).
//  Single array write port, with this priority:
//   - An accepted access write wins over a preload.
//   - Ld_ack = Ld_en & ~(En & Rw & ~Busy). A preload that is not acked is dropped;
//     the source must hold Ld_en until it sees Ld_ack.
//   - A preload and an accepted read to the same Addr in the same cycle: the read
//     returns the old word, the preload lands.
//  Counters:
//   - Rd_cnt and Wr_cnt increment at the accept edge and saturate at 2^CNT_W-1
//     with no wrap.
//   - Cnt_clr has priority over an increment in the same cycle.
//  Address arithmetic: Addr is used unmodified; no wrap or bounds logic is needed
//   because the full 2^A_WIDTH depth is implemented.
// STRUCTURE
//  Shared include file (with the initiators): `D_WIDTH, `A_WIDTH, the Rw encoding
//   (RD=0, WR=1), and the FSM state codes (IDLE, WAIT).
//  One sub-module, sat_counter (parameter CNT_W; ports clr, inc, q), instantiated
//   for Rd_cnt and Wr_cnt.
//  The array, read pipeline and FSM stay inline.
// TESTING
//  1) Preload 0x05->0x07, 0x06->0x0E; RD_LAT=1; read 0x05 at edge k
//     -> Data=0x07, Rdy=1 in cycle k+1, Busy stays 0, Rd_cnt=1.
//  2) RD_LAT=3; read 0x06 at edge k
//     -> Busy=1 for 2 cycles, Data=0x0E with Rdy at k+3, En pulses during Busy
//        ignored, Rd_cnt=1.
//  3) Write 0x2A to 0x10, then read 0x10 back-to-back (RD_LAT=1)
//     -> Wack pulse, read returns 0x2A, Wr_cnt=1.
//  4) Same cycle: access write 0x11->0x33 and Ld_en to 0x12
//     -> Ld_ack=0, 0x12 unchanged; source holds Ld_en and the preload lands next cycle.
//  5) Drive Rst=0 mid-read with RD_LAT=4
//     -> immediate Data=0, Busy=0, counters 0, no Rdy after release; array
//        contents preserved.
//  6) Force Rd_cnt to 0xFFFF (CNT_W=16) and read again -> stays 0xFFFF;
//     Cnt_clr together with a read -> 0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and the search initiators that drive it.
package mem_responder_pkg;

    // Default data and address widths used across the initiator/responder pair.
    localparam int D_WIDTH_DEF = 8;
    localparam int A_WIDTH_DEF = 8;

    // Latency countdown width; RD_LAT up to 4 needs a count of at most 2.
    localparam int LAT_W = 2;

    // Rw encoding on the request interface.
    typedef enum logic {
        RW_RD = 1'b0,
        RW_WR = 1'b1
    } rw_e;

    // Read-latency FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Countdown value loaded on entry to WAIT: the last WAIT edge loads Data.
    function automatic logic [LAT_W-1:0] lat_load(input int rd_lat);
        return LAT_W'(rd_lat - 2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_q;
    logic             w_full;

    assign w_full = (r_q == {CNT_W{1'b1}});

    // Count accepted events, hold at all-ones, clear on request.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            r_q <= '0;
        else if (clr)
            r_q <= '0;
        else if (inc && !w_full)
            r_q <= r_q + CNT_W'(1);
    end

    assign q = r_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: single-port array with programmable read latency,
// preload port sharing the write port, and access statistics.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int RD_LAT  = 1,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic               Rw,
    input  logic [A_WIDTH-1:0] Addr,
    input  logic [D_WIDTH-1:0] Wdata,
    output logic [D_WIDTH-1:0] Data,
    output logic               Rdy,
    output logic               Busy,
    output logic               Wack,
    input  logic               Ld_en,
    input  logic [A_WIDTH-1:0] Ld_addr,
    input  logic [D_WIDTH-1:0] Ld_data,
    output logic               Ld_ack,
    input  logic               Cnt_clr,
    output logic [CNT_W-1:0]   Rd_cnt,
    output logic [CNT_W-1:0]   Wr_cnt
);

    localparam int DEPTH  = 1 << A_WIDTH;
    localparam int PIPE_N = (RD_LAT > 1) ? RD_LAT - 1 : 1;

    logic [D_WIDTH-1:0] r_mem [DEPTH];

    state_e             r_state;
    state_e             w_state_nxt;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [LAT_W-1:0]   w_lat_nxt;

    logic [D_WIDTH-1:0] r_data;
    logic               r_rdy;
    logic               r_wack;

    logic               w_busy;
    logic               w_acc;
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic [D_WIDTH-1:0] w_rd_word;
    logic [D_WIDTH-1:0] w_pipe_out;
    logic               w_load;

    // Accept decode: En is level-sampled and ignored while a read is in flight.
    assign w_busy   = (r_state == ST_WAIT);
    assign w_acc    = En & ~w_busy;
    assign w_rd_acc = w_acc & (Rw == RW_RD);
    assign w_wr_acc = w_acc & (Rw == RW_WR);

    // An accepted access write owns the single write port; the preload waits.
    assign Ld_ack = Ld_en & ~w_wr_acc;

    // Read sees the array before any write landing on the same edge.
    assign w_rd_word = r_mem[Addr];

    // Single write port: access write first, otherwise an acked preload.
    always_ff @(posedge Clk) begin
        if (w_wr_acc)
            r_mem[Addr] <= Wdata;
        else if (Ld_en)
            r_mem[Ld_addr] <= Ld_data;
    end

    generate
        if (RD_LAT > 1) begin : g_pipe
            logic [D_WIDTH-1:0] r_pipe [PIPE_N];

            // Stage the sampled word so it reaches the last stage one edge before Data loads.
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    for (int i = 0; i < PIPE_N; i++)
                        r_pipe[i] <= '0;
                end else begin
                    if (w_rd_acc)
                        r_pipe[0] <= w_rd_word;
                    for (int i = 1; i < PIPE_N; i++)
                        r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign w_pipe_out = r_pipe[PIPE_N-1];
        end else begin : g_nopipe
            assign w_pipe_out = w_rd_word;
        end
    endgenerate

    // Data loads on the accept edge for single-cycle latency, else on the last WAIT edge.
    assign w_load = (RD_LAT == 1) ? w_rd_acc
                                  : (w_busy && (r_lat_cnt == '0));

    // Latency FSM state and countdown registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_nxt;
        end
    end

    // Next-state: enter WAIT on a multi-cycle read, count down, return when done.
    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_acc && (RD_LAT > 1)) begin
                    w_state_nxt = ST_WAIT;
                    w_lat_nxt   = lat_load(RD_LAT);
                end
            end
            ST_WAIT: begin
                if (r_lat_cnt == '0)
                    w_state_nxt = ST_IDLE;
                else
                    w_lat_nxt = r_lat_cnt - 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Response registers: Data holds until the next read, Rdy/Wack are one-cycle pulses.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_data <= '0;
            r_rdy  <= 1'b0;
            r_wack <= 1'b0;
        end else begin
            r_rdy  <= w_load;
            r_wack <= w_wr_acc;
            if (w_load)
                r_data <= w_pipe_out;
        end
    end

    assign Data = r_data;
    assign Rdy  = r_rdy;
    assign Busy = w_busy;
    assign Wack = r_wack;

    sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (Cnt_clr),
        .inc (w_rd_acc),
        .q   (Rd_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (Cnt_clr),
        .inc (w_wr_acc),
        .q   (Wr_cnt)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (RD_LAT 1, 3, 4); the RD_LAT=4 one
// uses a 4-bit counter so saturation is reachable in a few dozen reads.
module tb_mem_responder;

    typedef struct packed {
        logic       en;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       ld_en;
        logic [7:0] ld_addr;
        logic [7:0] ld_data;
        logic       clr;
    } req_t;

    logic       Clk;
    logic       rst    [3];
    req_t       req    [3];
    logic [7:0] data_o [3];
    logic       rdy_o  [3];
    logic       busy_o [3];
    logic       wack_o [3];
    logic       ldack_o[3];
    logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
    logic [3:0]  rdc_c, wrc_c;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    int n_cmp = 0;
    int n_bad = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    mem_responder #(.D_WIDTH(8), .A_WIDTH(8), .RD_LAT(1), .CNT_W(16)) u_a (
        .Clk(Clk), .Rst(rst[0]), .En(req[0].en), .Rw(req[0].rw), .Addr(req[0].addr),
        .Wdata(req[0].wdata), .Data(data_o[0]), .Rdy(rdy_o[0]), .Busy(busy_o[0]),
        .Wack(wack_o[0]), .Ld_en(req[0].ld_en), .Ld_addr(req[0].ld_addr),
        .Ld_data(req[0].ld_data), .Ld_ack(ldack_o[0]), .Cnt_clr(req[0].clr),
        .Rd_cnt(rdc_a), .Wr_cnt(wrc_a));

    mem_responder #(.D_WIDTH(8), .A_WIDTH(8), .RD_LAT(3), .CNT_W(16)) u_b (
        .Clk(Clk), .Rst(rst[1]), .En(req[1].en), .Rw(req[1].rw), .Addr(req[1].addr),
        .Wdata(req[1].wdata), .Data(data_o[1]), .Rdy(rdy_o[1]), .Busy(busy_o[1]),
        .Wack(wack_o[1]), .Ld_en(req[1].ld_en), .Ld_addr(req[1].ld_addr),
        .Ld_data(req[1].ld_data), .Ld_ack(ldack_o[1]), .Cnt_clr(req[1].clr),
        .Rd_cnt(rdc_b), .Wr_cnt(wrc_b));

    mem_responder #(.D_WIDTH(8), .A_WIDTH(8), .RD_LAT(4), .CNT_W(4)) u_c (
        .Clk(Clk), .Rst(rst[2]), .En(req[2].en), .Rw(req[2].rw), .Addr(req[2].addr),
        .Wdata(req[2].wdata), .Data(data_o[2]), .Rdy(rdy_o[2]), .Busy(busy_o[2]),
        .Wack(wack_o[2]), .Ld_en(req[2].ld_en), .Ld_addr(req[2].ld_addr),
        .Ld_data(req[2].ld_data), .Ld_ack(ldack_o[2]), .Cnt_clr(req[2].clr),
        .Rd_cnt(rdc_c), .Wr_cnt(wrc_c));

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Read-data monitors: every Rdy pulse must match the oldest expected word.
    always @(negedge Clk) begin
        if (rdy_o[0] === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_a: got Rdy=1 data=%0h expected no response", data_o[0]);
            end else chk("rd_a", {24'd0, data_o[0]}, {24'd0, q0.pop_front()});
        end
    end
    always @(negedge Clk) begin
        if (rdy_o[1] === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_b: got Rdy=1 data=%0h expected no response", data_o[1]);
            end else chk("rd_b", {24'd0, data_o[1]}, {24'd0, q1.pop_front()});
        end
    end
    always @(negedge Clk) begin
        if (rdy_o[2] === 1'b1) begin
            if (q2.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_c: got Rdy=1 data=%0h expected no response", data_o[2]);
            end else chk("rd_c", {24'd0, data_o[2]}, {24'd0, q2.pop_front()});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic push(input int d, input logic [7:0] e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic preload(input int d, input logic [7:0] a, input logic [7:0] v);
        req[d].ld_en = 1'b1; req[d].ld_addr = a; req[d].ld_data = v;
        cyc(1);
        req[d].ld_en = 1'b0;
    endtask

    task automatic wr(input int d, input logic [7:0] a, input logic [7:0] v);
        req[d].en = 1'b1; req[d].rw = 1'b1; req[d].addr = a; req[d].wdata = v;
        cyc(1);
        req[d].en = 1'b0; req[d].rw = 1'b0;
    endtask

    // Issue one read, then idle until it has fully completed.
    task automatic rd(input int d, input logic [7:0] a, input logic [7:0] e, input int lat);
        req[d].en = 1'b1; req[d].rw = 1'b0; req[d].addr = a;
        push(d, e);
        cyc(1);
        req[d].en = 1'b0;
        cyc(lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0;
            req[d] = '0;
        end
        cyc(2);
        // Reset state
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_data%0d", d), {24'd0, data_o[d]}, 32'h0);
            chk($sformatf("rst_rdy%0d", d),  {31'd0, rdy_o[d]}, 32'h0);
            chk($sformatf("rst_busy%0d", d), {31'd0, busy_o[d]}, 32'h0);
            chk($sformatf("rst_wack%0d", d), {31'd0, wack_o[d]}, 32'h0);
        end
        chk("rst_rdc_a", {16'd0, rdc_a}, 32'h0);
        chk("rst_wrc_b", {16'd0, wrc_b}, 32'h0);
        chk("rst_rdc_c", {28'd0, rdc_c}, 32'h0);
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        cyc(1);

        // 1) RD_LAT=1 read after preload
        preload(0, 8'h05, 8'h07);
        preload(0, 8'h06, 8'h0E);
        preload(0, 8'h12, 8'h44);
        req[0].en = 1'b1; req[0].rw = 1'b0; req[0].addr = 8'h05;
        push(0, 8'h07);
        cyc(1);
        req[0].en = 1'b0;
        chk("t1_rdy", {31'd0, rdy_o[0]}, 32'h1);
        chk("t1_busy", {31'd0, busy_o[0]}, 32'h0);
        chk("t1_rdc", {16'd0, rdc_a}, 32'h1);
        cyc(1);
        chk("t1_rdy_pulse", {31'd0, rdy_o[0]}, 32'h0);
        // back-to-back reads
        req[0].en = 1'b1; req[0].addr = 8'h05; push(0, 8'h07);
        cyc(1);
        chk("b2b_busy0", {31'd0, busy_o[0]}, 32'h0);
        req[0].addr = 8'h06; push(0, 8'h0E);
        cyc(1);
        req[0].en = 1'b0;
        chk("b2b_busy1", {31'd0, busy_o[0]}, 32'h0);
        chk("b2b_rdy", {31'd0, rdy_o[0]}, 32'h1);
        cyc(1);
        chk("b2b_rdc", {16'd0, rdc_a}, 32'h3);

        // 3) write then read back-to-back
        req[0].en = 1'b1; req[0].rw = 1'b1; req[0].addr = 8'h10; req[0].wdata = 8'h2A;
        cyc(1);
        chk("t3_wack", {31'd0, wack_o[0]}, 32'h1);
        req[0].rw = 1'b0; push(0, 8'h2A);
        cyc(1);
        req[0].en = 1'b0;
        chk("t3_wack_pulse", {31'd0, wack_o[0]}, 32'h0);
        chk("t3_wrc", {16'd0, wrc_a}, 32'h1);
        cyc(1);
        chk("t3_rdc", {16'd0, rdc_a}, 32'h4);

        // 4) access write blocks a preload; held preload lands next cycle alongside a read
        req[0].en = 1'b1; req[0].rw = 1'b1; req[0].addr = 8'h11; req[0].wdata = 8'h33;
        req[0].ld_en = 1'b1; req[0].ld_addr = 8'h12; req[0].ld_data = 8'h99;
        #1;
        chk("t4_ldack_blocked", {31'd0, ldack_o[0]}, 32'h0);
        cyc(1);
        req[0].rw = 1'b0; req[0].addr = 8'h12; push(0, 8'h44);
        #1;
        chk("t4_ldack_taken", {31'd0, ldack_o[0]}, 32'h1);
        cyc(1);
        req[0].en = 1'b0; req[0].ld_en = 1'b0;
        cyc(1);
        chk("t4_wrc", {16'd0, wrc_a}, 32'h2);
        rd(0, 8'h12, 8'h99, 1);
        rd(0, 8'h11, 8'h33, 1);
        chk("t4_rdc", {16'd0, rdc_a}, 32'h7);

        // 2) RD_LAT=3: Busy for two cycles, En ignored meanwhile
        preload(1, 8'h06, 8'h0E);
        preload(1, 8'h07, 8'h55);
        req[1].en = 1'b1; req[1].rw = 1'b0; req[1].addr = 8'h06;
        push(1, 8'h0E);
        #1;
        chk("t2_busy_pre", {31'd0, busy_o[1]}, 32'h0);
        cyc(1);
        req[1].addr = 8'h07;
        chk("t2_busy_k", {31'd0, busy_o[1]}, 32'h1);
        chk("t2_rdy_early", {31'd0, rdy_o[1]}, 32'h0);
        cyc(1);
        chk("t2_busy_k1", {31'd0, busy_o[1]}, 32'h1);
        cyc(1);
        req[1].en = 1'b0;
        chk("t2_busy_done", {31'd0, busy_o[1]}, 32'h0);
        chk("t2_rdy", {31'd0, rdy_o[1]}, 32'h1);
        chk("t2_rdc", {16'd0, rdc_b}, 32'h1);
        cyc(1);
        chk("t2_rdy_pulse", {31'd0, rdy_o[1]}, 32'h0);
        rd(1, 8'h07, 8'h55, 3);
        chk("t2_rdc2", {16'd0, rdc_b}, 32'h2);

        // 5) RD_LAT=4: reset mid-read
        preload(2, 8'h20, 8'hA5);
        wr(2, 8'h21, 8'h5A);
        rd(2, 8'h21, 8'h5A, 4);
        chk("t5_data_pre", {24'd0, data_o[2]}, 32'h5A);
        chk("t5_cnt_pre", {24'd0, rdc_c, wrc_c}, 32'h11);
        req[2].en = 1'b1; req[2].rw = 1'b0; req[2].addr = 8'h20;
        cyc(1);
        req[2].en = 1'b0;
        cyc(1);
        chk("t5_busy_mid", {31'd0, busy_o[2]}, 32'h1);
        rst[2] = 1'b0;
        #1;
        chk("t5_rst_data", {24'd0, data_o[2]}, 32'h0);
        chk("t5_rst_busy", {31'd0, busy_o[2]}, 32'h0);
        chk("t5_rst_rdy", {31'd0, rdy_o[2]}, 32'h0);
        chk("t5_rst_cnt", {24'd0, rdc_c, wrc_c}, 32'h0);
        cyc(2);
        rst[2] = 1'b1;
        cyc(6);
        rd(2, 8'h20, 8'hA5, 4);
        rd(2, 8'h21, 8'h5A, 4);
        chk("t5_rdc", {28'd0, rdc_c}, 32'h2);

        // 6) saturation and clear priority
        for (int i = 0; i < 13; i++) rd(2, 8'h20, 8'hA5, 4);
        chk("t6_rdc_full", {28'd0, rdc_c}, 32'hF);
        rd(2, 8'h20, 8'hA5, 4);
        chk("t6_rdc_sat", {28'd0, rdc_c}, 32'hF);
        req[2].en = 1'b1; req[2].rw = 1'b0; req[2].addr = 8'h20; req[2].clr = 1'b1;
        push(2, 8'hA5);
        cyc(1);
        req[2].en = 1'b0; req[2].clr = 1'b0;
        chk("t6_clr_rdc", {28'd0, rdc_c}, 32'h0);
        chk("t6_clr_wrc", {28'd0, wrc_c}, 32'h0);
        cyc(4);
        rd(2, 8'h21, 8'h5A, 4);
        chk("t6_rdc_after", {28'd0, rdc_c}, 32'h1);

        cyc(3);
        chk("q_a_drained", q0.size(), 32'h0);
        chk("q_b_drained", q1.size(), 32'h0);
        chk("q_c_drained", q2.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
